// File: rtl/writeback_retire_buffer_pkg.sv
// Shared types for the writeback retire buffer: per-entry payload, CSR op
// encoding and a few helpers used by the retire decode and bypass lookup.
package writeback_retire_buffer_pkg;

   localparam int DATA_W     = 32;
   localparam int CSR_ADDR_W = 12;
   localparam int RF_ADDR_W  = 5;

   typedef enum logic [2:0] {
      CSR_NONE = 3'd0,
      CSR_RW   = 3'd1,
      CSR_RS   = 3'd2,
      CSR_RC   = 3'd3,
      CSR_RWI  = 3'd4,
      CSR_RSI  = 3'd5,
      CSR_RCI  = 3'd6
   } csr_op_t;

   typedef struct packed {
      logic [RF_ADDR_W-1:0]  rd;
      logic [DATA_W-1:0]     data;
      logic                  wb_en;
      csr_op_t               csr_op;
      logic [CSR_ADDR_W-1:0] csr_addr;
      logic                  csr_wr_intent;
      logic [DATA_W-1:0]     old_csr;
      logic                  illegal;
   } retire_entry_t;

   localparam int ENTRY_W = $bits(retire_entry_t);

   // True when retiring this entry would write a non-zero destination register.
   function automatic logic writes_rd(input retire_entry_t e);
      return !e.illegal && (e.rd != '0) && ((e.csr_op != CSR_NONE) || e.wb_en);
   endfunction

   // Register-file value an entry produces: CSR ops return the old CSR value.
   function automatic logic [DATA_W-1:0] rd_value(input retire_entry_t e);
      return (e.csr_op != CSR_NONE) ? e.old_csr : e.data;
   endfunction

endpackage

// File: rtl/writeback_retire_buffer_if.sv
// Push handshake and retire (register file / CSR file) bus of the
// writeback retire buffer. master = producer/consumer side, slave = buffer.
import writeback_retire_buffer_pkg::*;

interface writeback_retire_buffer_if #(
   parameter int LANES = 2,
   parameter int XLEN  = DATA_W
);
   logic [LANES-1:0]                in_valid;
   retire_entry_t [LANES-1:0]       in_entry;
   logic                            in_ready;
   logic                            rf_we;
   logic [RF_ADDR_W-1:0]            rf_addr;
   logic [XLEN-1:0]                 rf_data;
   logic                            csr_we;
   logic [CSR_ADDR_W-1:0]           csr_addr;
   logic [XLEN-1:0]                 csr_data;
   logic                            retire_valid;
   logic                            retire_illegal;

   modport master (
      output in_valid, in_entry,
      input  in_ready, rf_we, rf_addr, rf_data, csr_we, csr_addr, csr_data,
             retire_valid, retire_illegal
   );

   modport slave (
      input  in_valid, in_entry,
      output in_ready, rf_we, rf_addr, rf_data, csr_we, csr_addr, csr_data,
             retire_valid, retire_illegal
   );
endinterface

// File: rtl/writeback_retire_buffer_fifo.sv
// rb_multi_push_fifo: in-order queue accepting up to LANES sparse lanes per
// cycle (compacted into consecutive slots) and popping one entry per cycle.
// Flush empties the queue by snapping head onto tail.
// With RETIRE_BYPASS_EN the raw slots and head pointer are exported.
module rb_multi_push_fifo #(
   parameter int LANES = 2,
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [LANES-1:0]            push_valid_i,
   input  logic [LANES-1:0][W-1:0]     push_data_i,
   output logic                        push_ready_o,
   input  logic                        pop_i,
   input  logic                        flush_i,
   output logic [W-1:0]                head_data_o,
   output logic [$clog2(DEPTH):0]      count_o
`ifdef RETIRE_BYPASS_EN
   ,
   output logic [DEPTH-1:0][W-1:0]     slots_o,
   output logic [$clog2(DEPTH)-1:0]    head_ptr_o
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] pushed;
   logic [CNT_W-1:0] off [LANES];
   logic             push_fire, pop_fire;

   // Ready is judged on the current fill level only, never the post-pop one.
   assign push_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(LANES);
   assign push_fire    = push_ready_o && (|push_valid_i) && !flush_i;
   assign pop_fire     = pop_i && (count_q != '0) && !flush_i;

   // Slot offset of each lane = number of valid lanes below it.
   always_comb begin
      pushed = '0;
      for (int l = 0; l < LANES; l++) begin
         off[l] = pushed;
         pushed = pushed + CNT_W'(push_valid_i[l]);
      end
   end

   // Next pointers and fill level; flush overrides push and pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = tail_q;
         count_d = '0;
      end else begin
         if (push_fire) tail_d = tail_q + pushed[PTR_W-1:0];
         if (pop_fire)  head_d = head_q + PTR_W'(1);
         count_d = count_q + (push_fire ? pushed : '0) - (pop_fire ? CNT_W'(1) : '0);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage write: each valid lane lands at tail + its compacted offset.
   always_ff @(posedge clock) begin
      if (!reset && push_fire) begin
         for (int l = 0; l < LANES; l++) begin
            if (push_valid_i[l]) mem_q[tail_q + off[l][PTR_W-1:0]] <= push_data_i[l];
         end
      end
   end

   assign head_data_o = mem_q[head_q];
   assign count_o     = count_q;

`ifdef RETIRE_BYPASS_EN
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slots
         assign slots_o[gi] = mem_q[gi];
      end
   endgenerate
   assign head_ptr_o = head_q;
`endif

endmodule

// File: rtl/writeback_retire_buffer.sv
// writeback_retire_buffer: multi-lane in-order retire queue feeding the
// register file and CSR file, one entry per cycle, with flush, hold and a
// 64-bit retired-instruction counter. XLEN must equal the package DATA_W.
// Optional feature macro: RETIRE_BYPASS_EN (register lookup into the queue).
import writeback_retire_buffer_pkg::*;

module writeback_retire_buffer #(
   parameter int LANES = 2,
   parameter int DEPTH = 8,
   parameter int XLEN  = DATA_W
) (
   input  logic                       clock,
   input  logic                       reset,
   writeback_retire_buffer_if.slave   bus,
   input  logic                       flush_i,
   input  logic                       hold_i,
   output logic [63:0]                instret_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
`ifdef RETIRE_BYPASS_EN
   ,
   input  logic [RF_ADDR_W-1:0]       lookup_addr_i,
   output logic                       lookup_hit_o,
   output logic [XLEN-1:0]            lookup_data_o
`endif
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [LANES-1:0][ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0]            head_bits;
   logic [CNT_W-1:0]              count;
   retire_entry_t                 head;
   logic                          pop_en;
   logic [63:0]                   instret_q;

`ifdef RETIRE_BYPASS_EN
   logic [DEPTH-1:0][ENTRY_W-1:0] slots;
   logic [PTR_W-1:0]              head_ptr;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lanes
         assign push_data[gi] = bus.in_entry[gi];
      end
   endgenerate

   rb_multi_push_fifo #(
      .LANES (LANES),
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_valid_i (bus.in_valid),
      .push_data_i  (push_data),
      .push_ready_o (bus.in_ready),
      .pop_i        (pop_en),
      .flush_i      (flush_i),
      .head_data_o  (head_bits),
      .count_o      (count)
`ifdef RETIRE_BYPASS_EN
      ,
      .slots_o      (slots),
      .head_ptr_o   (head_ptr)
`endif
   );

   assign head        = retire_entry_t'(head_bits);
   assign pop_en      = (count != '0) && !hold_i && !flush_i;
   assign occupancy_o = count;
   assign instret_o   = instret_q;

   // Retire decode: drive the write ports from the head entry while it pops.
   always_comb begin
      bus.retire_valid   = 1'b0;
      bus.retire_illegal = 1'b0;
      bus.rf_we          = 1'b0;
      bus.rf_addr        = '0;
      bus.rf_data        = '0;
      bus.csr_we         = 1'b0;
      bus.csr_addr       = '0;
      bus.csr_data       = '0;
      if (pop_en) begin
         bus.retire_valid   = 1'b1;
         bus.retire_illegal = head.illegal;
         bus.rf_addr        = head.rd;
         bus.csr_addr       = head.csr_addr;
         if (head.csr_op != CSR_NONE) begin
            bus.rf_data  = XLEN'(head.old_csr);
            bus.rf_we    = !head.illegal && (head.rd != '0);
            bus.csr_we   = !head.illegal && head.csr_wr_intent;
            bus.csr_data = XLEN'(head.data);
         end else begin
            bus.rf_data  = XLEN'(head.data);
            bus.rf_we    = head.wb_en && !head.illegal && (head.rd != '0);
         end
      end
   end

   // Retired-instruction counter: legal retires only, wraps naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         instret_q <= '0;
      end else if (pop_en && !head.illegal) begin
         instret_q <= instret_q + 64'd1;
      end
   end

`ifdef RETIRE_BYPASS_EN
   retire_entry_t slot_e;
   // Scan oldest to youngest so the youngest matching writer wins.
   always_comb begin
      lookup_hit_o  = 1'b0;
      lookup_data_o = '0;
      slot_e        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_e = retire_entry_t'(slots[head_ptr + PTR_W'(i)]);
         if ((CNT_W'(i) < count) && writes_rd(slot_e) && (slot_e.rd == lookup_addr_i)) begin
            lookup_hit_o  = 1'b1;
            lookup_data_o = XLEN'(rd_value(slot_e));
         end
      end
   end
`endif

endmodule

// File: tb/tb_writeback_retire_buffer.sv
// Directed testbench for writeback_retire_buffer (LANES=2, DEPTH=8, XLEN=32).
import writeback_retire_buffer_pkg::*;

module tb_writeback_retire_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        hold;
   logic [63:0] instret;
   logic [3:0]  occupancy;
   int          n_checks = 0;
   int          n_pass   = 0;

`ifdef RETIRE_BYPASS_EN
   logic [4:0]  lookup_addr;
   logic        lookup_hit;
   logic [31:0] lookup_data;
`endif

   always #5 clock = ~clock;

   writeback_retire_buffer_if #(.LANES(2), .XLEN(32)) bus ();

   writeback_retire_buffer #(.LANES(2), .DEPTH(8), .XLEN(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .flush_i     (flush),
      .hold_i      (hold),
      .instret_o   (instret),
      .occupancy_o (occupancy)
`ifdef RETIRE_BYPASS_EN
      ,
      .lookup_addr_i (lookup_addr),
      .lookup_hit_o  (lookup_hit),
      .lookup_data_o (lookup_data)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic retire_entry_t mk(input logic [4:0] rd, input logic [31:0] data,
                                        input logic wb, input csr_op_t op,
                                        input logic [11:0] ca, input logic intent,
                                        input logic [31:0] old, input logic ill);
      retire_entry_t e;
      e.rd = rd; e.data = data; e.wb_en = wb; e.csr_op = op; e.csr_addr = ca;
      e.csr_wr_intent = intent; e.old_csr = old; e.illegal = ill;
      return e;
   endfunction

   function automatic retire_entry_t alu(input logic [4:0] rd, input logic [31:0] data);
      return mk(rd, data, 1'b1, CSR_NONE, 12'h0, 1'b0, 32'h0, 1'b0);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   task automatic offer(input logic [1:0] v, input retire_entry_t e0, input retire_entry_t e1);
      bus.in_valid    = v;
      bus.in_entry[0] = e0;
      bus.in_entry[1] = e1;
      $display("push valid=%b lane0 rd=%0d data=0x%0h lane1 rd=%0d data=0x%0h",
               v, e0.rd, e0.data, e1.rd, e1.data);
   endtask

   task automatic idle();
      bus.in_valid = 2'b00;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; hold = 1'b0;
      bus.in_valid = 2'b00;
      bus.in_entry[0] = '0;
      bus.in_entry[1] = '0;
`ifdef RETIRE_BYPASS_EN
      lookup_addr = 5'd0;
`endif
      step(); step(); look();
      check("rst_occ", 64'(occupancy), 64'd0);
      check("rst_instret", instret, 64'd0);
      check("rst_rv", 64'(bus.retire_valid), 64'd0);
      check("rst_rfwe", 64'(bus.rf_we), 64'd0);
      check("rst_csrwe", 64'(bus.csr_we), 64'd0);
      check("rst_ready", 64'(bus.in_ready), 64'd1);
      reset = 1'b0;

      // Basic push of two lanes, retire in order, rd=0 suppresses write.
      offer(2'b11, alu(5'd5, 32'h11), alu(5'd0, 32'h22));
      step(); idle(); look();
      check("basic_we0", 64'(bus.rf_we), 64'd1);
      check("basic_addr0", 64'(bus.rf_addr), 64'd5);
      check("basic_data0", 64'(bus.rf_data), 64'h11);
      check("basic_rv0", 64'(bus.retire_valid), 64'd1);
      check("basic_occ0", 64'(occupancy), 64'd2);
      step(); look();
      check("basic_we1", 64'(bus.rf_we), 64'd0);
      check("basic_rv1", 64'(bus.retire_valid), 64'd1);
      check("basic_data1", 64'(bus.rf_data), 64'h22);
      step(); look();
      check("basic_rv2", 64'(bus.retire_valid), 64'd0);
      check("basic_instret", instret, 64'd2);

      // Fill under hold, offer while full, then drain in order.
      hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         offer(2'b11, alu(5'(2*k+1), 32'((2*k+1)*16)), alu(5'(2*k+2), 32'((2*k+2)*16)));
         step();
      end
      idle(); look();
      check("full_occ", 64'(occupancy), 64'd8);
      check("full_ready", 64'(bus.in_ready), 64'd0);
      check("full_rv", 64'(bus.retire_valid), 64'd0);
      offer(2'b11, alu(5'd20, 32'h200), alu(5'd21, 32'h210));
      step(); idle(); look();
      check("full_ignored", 64'(occupancy), 64'd8);
      hold = 1'b0;
      for (int i = 0; i < 8; i++) begin
         look();
         check("drain_addr", 64'(bus.rf_addr), 64'(i+1));
         check("drain_data", 64'(bus.rf_data), 64'((i+1)*16));
         if (i == 0) check("drain_ready_cur", 64'(bus.in_ready), 64'd0);
         $display("retire rd=%0d data=0x%0h", bus.rf_addr, bus.rf_data);
         step();
      end
      look();
      check("drain_occ", 64'(occupancy), 64'd0);
      check("drain_instret", instret, 64'd10);

      // Sparse lanes: only lane 1 valid.
      offer(2'b10, alu(5'd30, 32'hDEAD), alu(5'd9, 32'h99));
      step(); idle(); look();
      check("sparse_occ", 64'(occupancy), 64'd1);
      check("sparse_addr", 64'(bus.rf_addr), 64'd9);
      check("sparse_data", 64'(bus.rf_data), 64'h99);
      step();

      // CSR ops: write intent on lane 0, read-only with rd=0 on lane 1.
      offer(2'b11, mk(5'd3, 32'hABC, 1'b0, CSR_RW, 12'h305, 1'b1, 32'h100, 1'b0),
                   mk(5'd0, 32'h55, 1'b0, CSR_RS, 12'h300, 1'b0, 32'h77, 1'b0));
      step(); idle(); look();
      check("csr_rfwe", 64'(bus.rf_we), 64'd1);
      check("csr_rfaddr", 64'(bus.rf_addr), 64'd3);
      check("csr_rfdata", 64'(bus.rf_data), 64'h100);
      check("csr_we", 64'(bus.csr_we), 64'd1);
      check("csr_addr", 64'(bus.csr_addr), 64'h305);
      check("csr_data", 64'(bus.csr_data), 64'hABC);
      step(); look();
      check("csr2_rfwe", 64'(bus.rf_we), 64'd0);
      check("csr2_we", 64'(bus.csr_we), 64'd0);
      check("csr2_addr", 64'(bus.csr_addr), 64'h300);
      step(); look();
      check("csr_instret", instret, 64'd13);

      // Illegal entry pops without writes or counting.
      offer(2'b01, mk(5'd4, 32'h44, 1'b1, CSR_RW, 12'h305, 1'b1, 32'h1, 1'b1), alu(5'd0, 32'h0));
      step(); idle(); look();
      check("ill_rv", 64'(bus.retire_valid), 64'd1);
      check("ill_flag", 64'(bus.retire_illegal), 64'd1);
      check("ill_rfwe", 64'(bus.rf_we), 64'd0);
      check("ill_csrwe", 64'(bus.csr_we), 64'd0);
      step(); look();
      check("ill_instret", instret, 64'd13);

`ifdef RETIRE_BYPASS_EN
      // Bypass: youngest legal writer of rd=7 wins; illegal younger one ignored.
      hold = 1'b1;
      lookup_addr = 5'd7;
      offer(2'b11, alu(5'd7, 32'h1), alu(5'd7, 32'h2));
      step();
      offer(2'b01, mk(5'd7, 32'h3, 1'b1, CSR_NONE, 12'h0, 1'b0, 32'h0, 1'b1), alu(5'd0, 32'h0));
      step(); idle(); look();
      check("byp_hit", 64'(lookup_hit), 64'd1);
      check("byp_data", 64'(lookup_data), 64'h2);
      lookup_addr = 5'd8; look();
      check("byp_miss", 64'(lookup_hit), 64'd0);
      flush = 1'b1;
      step(); flush = 1'b0;
      lookup_addr = 5'd7; look();
      check("byp_flushed", 64'(lookup_hit), 64'd0);
      hold = 1'b0;
`endif

      // Flush with a simultaneous push: everything discarded.
      hold = 1'b1;
      offer(2'b11, alu(5'd1, 32'h1), alu(5'd2, 32'h2)); step();
      offer(2'b11, alu(5'd3, 32'h3), alu(5'd4, 32'h4)); step();
      offer(2'b01, alu(5'd5, 32'h5), alu(5'd0, 32'h0)); step();
      idle(); look();
      check("fl_occ5", 64'(occupancy), 64'd5);
      hold = 1'b0;
      flush = 1'b1;
      offer(2'b11, alu(5'd8, 32'h8), alu(5'd9, 32'h9));
      look();
      check("fl_rv", 64'(bus.retire_valid), 64'd0);
      check("fl_rfwe", 64'(bus.rf_we), 64'd0);
      step(); flush = 1'b0; idle(); look();
      check("fl_occ0", 64'(occupancy), 64'd0);
      check("fl_rv_after", 64'(bus.retire_valid), 64'd0);
      check("fl_instret", instret, 64'd13);
      offer(2'b01, alu(5'd6, 32'h66), alu(5'd0, 32'h0));
      step(); idle(); look();
      check("fl_realign_addr", 64'(bus.rf_addr), 64'd6);
      check("fl_realign_data", 64'(bus.rf_data), 64'h66);
      check("fl_realign_occ", 64'(occupancy), 64'd1);
      step(); look();
      check("fl_realign_instret", instret, 64'd14);

      // Simultaneous push and pop.
      offer(2'b11, alu(5'd10, 32'hA0), alu(5'd11, 32'hB0));
      step();
      offer(2'b11, alu(5'd12, 32'hC0), alu(5'd13, 32'hD0));
      look();
      check("pp_addr", 64'(bus.rf_addr), 64'd10);
      check("pp_ready", 64'(bus.in_ready), 64'd1);
      step(); idle(); look();
      check("pp_occ", 64'(occupancy), 64'd3);
      check("pp_addr2", 64'(bus.rf_addr), 64'd11);
      step(); step(); step(); look();
      check("pp_occ_end", 64'(occupancy), 64'd0);
      check("pp_instret", instret, 64'd18);

      // Reset mid-operation, together with flush.
      hold = 1'b1;
      offer(2'b11, alu(5'd1, 32'h1), alu(5'd2, 32'h2));
      step(); idle();
      reset = 1'b1; flush = 1'b1;
      step(); look();
      check("mrst_occ", 64'(occupancy), 64'd0);
      check("mrst_instret", instret, 64'd0);
      reset = 1'b0; flush = 1'b0; hold = 1'b0;
      look();
      check("mrst_rv", 64'(bus.retire_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
